eth_port_tx: RTL and testbench
==============================

// Module: eth_port_tx
// PURPOSE
//  Store-and-forward packet transmitter for one switch port. Accepts words from
//  an upstream packet source, buffers each packet, and replays whole packets
//  onto the port input bus (data, SOP/EOP pulses) that the switch and monitor
//  sample. Instantiated once per port (A, B). Port stall is honoured between packets.
// PARAMETERS
//  DW       32   data width (matches the port data bus)
//  DEPTH    64   buffer depth in words; power of 2; must be >= MAX_PKT
//  MAX_PKT  32   max packet length in words; longer packets are truncated
//  GAP      1    min idle cycles between EOP and the next SOP (0 allowed)
// PORTS
//  clk        in   1        clock, all logic on posedge
//  reset      in   1        async, active-high reset
//  wr_valid   in   1        upstream word valid
//  wr_ready   out  1        buffer can accept a word (= !full)
//  wr_data    in   DW       upstream word
//  wr_last    in   1        last word of packet
//  tx_stall   in   1        port backpressure; blocks start of a new packet
//  tx_data    out  DW       port data (to inDataA/inDataB)
//  tx_sop     out  1        first-word pulse (to inSopA/inSopB)
//  tx_eop     out  1        last-word pulse (to inEopA/inEopB)
//  tx_busy    out  1        high from SOP cycle through EOP cycle
//  pkt_cnt    out  clog2(DEPTH)+1  complete packets held in buffer
//  trunc_err  out  1        1-cycle pulse when a packet is truncated
// BEHAVIOUR
//  Reset: all outputs 0 except wr_ready=1. Buffer, pkt_cnt, gap counter cleared.
//   Reset mid-packet: outputs drop to 0 immediately; buffered and partial packets lost.
//  Write side: word accepted when wr_valid & wr_ready; stored as {wr_last,wr_data}.
//   Word counter per packet; if the MAX_PKT-th word arrives without wr_last, it is
//   stored with last=1 and trunc_err pulses next cycle; following words up to and
//   including wr_last are discarded (wr_ready stays high while discarding).
//   pkt_cnt increments the cycle after a last word is stored.
//  wr_ready depends only on full; no pass-through, so a read while full does not
//   enable a write in the same cycle.
//  FSM (registered outputs):
//   IDLE: tx_sop/eop=0, tx_data=0. At edge k, if pkt_cnt>0, tx_stall=1'b0 sampled
//    at k, and gap counter==0: pop a word; after k tx_data=word, tx_sop=1,
//    tx_eop=word.last, tx_busy=1. If last -> stay IDLE (load gap counter), else SEND.
//   SEND: pop one word every cycle; tx_sop=0, tx_eop=word.last; tx_stall ignored.
//    On last -> IDLE, gap counter loaded with GAP, pkt_cnt decremented.
//   Between packets tx_data=0, tx_busy=0. GAP=0 allows SOP the cycle after EOP.
//  Latency: last word written at edge N -> earliest SOP registered at edge N+2.
//  Packet always contiguous: no idle/hold cycles between SOP and EOP.
//  1-word packet: tx_sop and tx_eop high in the same cycle.
//  Simultaneous packet complete (write) and packet sent (read): pkt_cnt unchanged.
//  Pointers wrap modulo DEPTH; full/empty by extra pointer bit.
// TESTING
//  1) 4-word pkt 0x11..0x14, stall=0, GAP=1 -> SOP with 0x11 at N+2, EOP with 0x14 3 cycles later.
//  2) Two 1-word pkts back-to-back, GAP=0 -> SOP&EOP high on 2 consecutive cycles; GAP=2 -> 2 idle cycles between.
//  3) Stall=1 held 10 cycles with 1 pkt stored -> no SOP; stall drop -> SOP next edge; stall
//     raised mid-packet -> packet completes unchanged.
//  4) 40-word pkt, MAX_PKT=32 -> 32 words sent, EOP on word 32, trunc_err one pulse, 8 words dropped.
//  5) Fill 64 words with tx_stall=1 -> wr_ready=0 at full; release stall -> words drain in order, wr_ready returns.
//  6) Assert reset during word 3 of a 6-word pkt -> tx_sop/eop/data/busy=0 immediately, pkt_cnt=0, no SOP after release.

Source files
------------

// File: rtl/eth_port_tx.sv
// Store-and-forward packet transmitter for one switch port: buffers whole packets
// from upstream and replays them contiguously onto the port bus with SOP/EOP pulses.
module eth_port_tx #(
   parameter int unsigned DW      = 32,
   parameter int unsigned DEPTH   = 64,
   parameter int unsigned MAX_PKT = 32,
   parameter int unsigned GAP     = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     wr_valid_i,
   output logic                     wr_ready_o,
   input  logic [DW-1:0]            wr_data_i,
   input  logic                     wr_last_i,
   input  logic                     tx_stall_i,
   output logic [DW-1:0]            tx_data_o,
   output logic                     tx_sop_o,
   output logic                     tx_eop_o,
   output logic                     tx_busy_o,
   output logic [$clog2(DEPTH):0]   pkt_cnt_o,
   output logic                     trunc_err_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(MAX_PKT + 1);
   localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

   localparam logic [AW:0]   PtrOne = (AW + 1)'(1);
   localparam logic [CW-1:0] CntOne = CW'(1);
   localparam logic [GW-1:0] GapOne = GW'(1);

   typedef enum logic {StIdle, StSend} state_e;

   state_e          state_q, state_d;
   logic [DW:0]     mem_q [DEPTH];
   logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]     pkt_cnt_q, pkt_cnt_d;
   logic [CW-1:0]   wcnt_q, wcnt_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic            discard_q, discard_d;
   logic            trunc_q, trunc_d;
   logic            done_q, done_d;
   logic [DW-1:0]   tx_data_q, tx_data_d;
   logic            tx_sop_q, tx_sop_d, tx_eop_q, tx_eop_d, tx_busy_q, tx_busy_d;

   logic            full, wr_fire, store, at_max, last_eff, pop, pop_last;
   logic [DW:0]     rd_word;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign wr_fire  = wr_valid_i & ~full;
   assign store    = wr_fire & ~discard_q;
   assign at_max   = (wcnt_q == CW'(MAX_PKT - 1));
   assign last_eff = wr_last_i | at_max;
   assign rd_word  = mem_q[rd_ptr_q[AW-1:0]];
   assign pop_last = pop & rd_word[DW];

   always_comb begin : write_side
      wr_ptr_d  = wr_ptr_q;
      wcnt_d    = wcnt_q;
      discard_d = discard_q;
      trunc_d   = 1'b0;
      done_d    = 1'b0;
      if (wr_fire && discard_q) begin
         if (wr_last_i) discard_d = 1'b0;
      end else if (store) begin
         wr_ptr_d = wr_ptr_q + PtrOne;
         done_d   = last_eff;
         if (last_eff) begin
            wcnt_d    = '0;
            trunc_d   = ~wr_last_i;
            discard_d = ~wr_last_i;
         end else begin
            wcnt_d = wcnt_q + CntOne;
         end
      end
   end

   always_comb begin : read_side
      rd_ptr_d = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
      gap_d    = gap_q;
      if (pop_last) begin
         gap_d = GW'(GAP);
      end else if (gap_q != '0) begin
         gap_d = gap_q - GapOne;
      end
      // A packet completing and one leaving in the same cycle cancel out.
      pkt_cnt_d = pkt_cnt_q;
      if (done_q && !pop_last) begin
         pkt_cnt_d = pkt_cnt_q + PtrOne;
      end else if (!done_q && pop_last) begin
         pkt_cnt_d = pkt_cnt_q - PtrOne;
      end
   end

   always_comb begin : pop_ctl
      pop = 1'b0;
      unique case (state_q)
         StIdle: pop = (pkt_cnt_q != '0) && !tx_stall_i && (gap_q == '0);
         StSend: pop = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin : fsm_reg
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin : fsm_next
      state_d = state_q;
      unique case (state_q)
         StIdle: if (pop && !rd_word[DW]) state_d = StSend;
         StSend: if (rd_word[DW]) state_d = StIdle;
      endcase
   end

   always_comb begin : fsm_out
      tx_data_d = '0;
      tx_sop_d  = 1'b0;
      tx_eop_d  = 1'b0;
      tx_busy_d = 1'b0;
      if (pop) begin
         tx_data_d = rd_word[DW-1:0];
         tx_sop_d  = (state_q == StIdle);
         tx_eop_d  = rd_word[DW];
         tx_busy_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin : buf_mem
      if (store) mem_q[wr_ptr_q[AW-1:0]] <= {last_eff, wr_data_i};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin : regs
      if (rst_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         pkt_cnt_q <= '0;
         wcnt_q    <= '0;
         gap_q     <= '0;
         discard_q <= 1'b0;
         trunc_q   <= 1'b0;
         done_q    <= 1'b0;
         tx_data_q <= '0;
         tx_sop_q  <= 1'b0;
         tx_eop_q  <= 1'b0;
         tx_busy_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         pkt_cnt_q <= pkt_cnt_d;
         wcnt_q    <= wcnt_d;
         gap_q     <= gap_d;
         discard_q <= discard_d;
         trunc_q   <= trunc_d;
         done_q    <= done_d;
         tx_data_q <= tx_data_d;
         tx_sop_q  <= tx_sop_d;
         tx_eop_q  <= tx_eop_d;
         tx_busy_q <= tx_busy_d;
      end
   end

   assign wr_ready_o  = ~full;
   assign tx_data_o   = tx_data_q;
   assign tx_sop_o    = tx_sop_q;
   assign tx_eop_o    = tx_eop_q;
   assign tx_busy_o   = tx_busy_q;
   assign pkt_cnt_o   = pkt_cnt_q;
   assign trunc_err_o = trunc_q;

endmodule

// File: tb/tb_eth_port_tx.sv
// Bench for eth_port_tx: three ports with GAP 1/0/2 share one upstream stream and are
// checked every cycle against a packet-level model, plus literal checks of key timings.
module tb_eth_port_tx;

   localparam int NI    = 3;
   localparam int DEPTH = 64;
   localparam int MAXP  = 32;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           wr_valid = 1'b0, wr_last = 1'b0, tx_stall = 1'b0;
   logic [31:0]    wr_data = '0;
   logic [NI-1:0]  wr_ready, tx_sop, tx_eop, tx_busy, trunc;
   logic [31:0]    tx_data [NI];
   logic [6:0]     pkt_cnt [NI];

   eth_port_tx #(.DW(32), .DEPTH(64), .MAX_PKT(32), .GAP(1)) u_g1 (
      .clk_i(clk), .rst_i(rst), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready[0]),
      .wr_data_i(wr_data), .wr_last_i(wr_last), .tx_stall_i(tx_stall),
      .tx_data_o(tx_data[0]), .tx_sop_o(tx_sop[0]), .tx_eop_o(tx_eop[0]),
      .tx_busy_o(tx_busy[0]), .pkt_cnt_o(pkt_cnt[0]), .trunc_err_o(trunc[0]));
   eth_port_tx #(.DW(32), .DEPTH(64), .MAX_PKT(32), .GAP(0)) u_g0 (
      .clk_i(clk), .rst_i(rst), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready[1]),
      .wr_data_i(wr_data), .wr_last_i(wr_last), .tx_stall_i(tx_stall),
      .tx_data_o(tx_data[1]), .tx_sop_o(tx_sop[1]), .tx_eop_o(tx_eop[1]),
      .tx_busy_o(tx_busy[1]), .pkt_cnt_o(pkt_cnt[1]), .trunc_err_o(trunc[1]));
   eth_port_tx #(.DW(32), .DEPTH(64), .MAX_PKT(32), .GAP(2)) u_g2 (
      .clk_i(clk), .rst_i(rst), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready[2]),
      .wr_data_i(wr_data), .wr_last_i(wr_last), .tx_stall_i(tx_stall),
      .tx_data_o(tx_data[2]), .tx_sop_o(tx_sop[2]), .tx_eop_o(tx_eop[2]),
      .tx_busy_o(tx_busy[2]), .pkt_cnt_o(pkt_cnt[2]), .trunc_err_o(trunc[2]));

   always #5 clk = ~clk;

   // Model: per port, a word queue, the store cycle of every complete packet not yet
   // fully sent, and the earliest cycle a new SOP may occur.
   logic [32:0] mq [NI][$];
   int          rdy [NI][$];
   bit          in_pkt [NI], disc [NI];
   int          wcnt [NI], next_ok [NI], trunc_at [NI], e_cnt [NI];
   logic [31:0] e_data [NI];
   logic        e_sop [NI], e_eop [NI], e_busy [NI], e_rdy [NI], e_trunc [NI];
   int          cyc = 0;
   int          npass = 0, ntot = 0;
   int          busy_n = 0, eop_n = 0, trunc_n = 0;
   bit          rnd_mode = 0;

   function automatic int gap_of(input int i);
      return (i == 0) ? 1 : (i == 1) ? 0 : 2;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         mq[i].delete(); rdy[i].delete();
         in_pkt[i] = 0; disc[i] = 0; wcnt[i] = 0; next_ok[i] = 0; trunc_at[i] = -1;
         e_data[i] = '0; e_sop[i] = 0; e_eop[i] = 0; e_busy[i] = 0;
         e_rdy[i] = 1; e_trunc[i] = 0; e_cnt[i] = 0;
      end
   endtask

   task automatic model_step();
      logic [32:0] w;
      int          sz;
      cyc++;
      for (int i = 0; i < NI; i++) begin
         sz = mq[i].size();
         e_sop[i] = 0; e_eop[i] = 0; e_busy[i] = 0; e_data[i] = '0;
         if (in_pkt[i] || (rdy[i].size() > 0 && rdy[i][0] + 2 <= cyc && !tx_stall &&
                           cyc >= next_ok[i])) begin
            w = mq[i].pop_front();
            e_sop[i] = !in_pkt[i]; e_busy[i] = 1; e_data[i] = w[31:0]; e_eop[i] = w[32];
            in_pkt[i] = !w[32];
            if (w[32]) begin
               void'(rdy[i].pop_front());
               next_ok[i] = cyc + gap_of(i) + 1;
            end
         end
         if (wr_valid && sz < DEPTH) begin
            if (disc[i]) begin
               if (wr_last) disc[i] = 0;
            end else begin
               wcnt[i]++;
               if (wr_last || wcnt[i] == MAXP) begin
                  mq[i].push_back({1'b1, wr_data});
                  rdy[i].push_back(cyc);
                  if (!wr_last) begin disc[i] = 1; trunc_at[i] = cyc; end
                  wcnt[i] = 0;
               end else begin
                  mq[i].push_back({1'b0, wr_data});
               end
            end
         end
         e_trunc[i] = (trunc_at[i] == cyc);
         e_rdy[i]   = mq[i].size() < DEPTH;
         e_cnt[i]   = 0;
         for (int k = 0; k < rdy[i].size(); k++) if (rdy[i][k] + 1 <= cyc) e_cnt[i]++;
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("p%0d tx_data", i), tx_data[i], e_data[i]);
         chk($sformatf("p%0d tx_sop", i), 32'(tx_sop[i]), 32'(e_sop[i]));
         chk($sformatf("p%0d tx_eop", i), 32'(tx_eop[i]), 32'(e_eop[i]));
         chk($sformatf("p%0d tx_busy", i), 32'(tx_busy[i]), 32'(e_busy[i]));
         chk($sformatf("p%0d wr_ready", i), 32'(wr_ready[i]), 32'(e_rdy[i]));
         chk($sformatf("p%0d trunc_err", i), 32'(trunc[i]), 32'(e_trunc[i]));
         chk($sformatf("p%0d pkt_cnt", i), 32'(pkt_cnt[i]), 32'(e_cnt[i]));
      end
      busy_n  += int'(tx_busy[0]);
      eop_n   += int'(tx_eop[0]);
      trunc_n += int'(trunc[0]);
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      @(negedge clk);
      compare_all();
      if (rnd_mode) tx_stall = ($urandom_range(0, 3) == 0);
   endtask

   task automatic send_word(input logic [31:0] d, input logic l);
      int n = 0;
      while (wr_ready !== 3'b111 && n < 500) begin tick(); n++; end
      if (n >= 500) begin
         ntot++;
         $display("FAIL send_word timeout: wr_ready %b, want 111", wr_ready);
      end else begin
         wr_valid = 1; wr_data = d; wr_last = l;
         tick();
         wr_valid = 0; wr_data = '0; wr_last = 0;
      end
   endtask

   task automatic wait_idle(input int maxc);
      int n = 0;
      while (!(tx_busy == '0 && pkt_cnt[0] == 0 && pkt_cnt[1] == 0 && pkt_cnt[2] == 0) &&
             n < maxc) begin
         tick(); n++;
      end
      if (n >= maxc) begin
         ntot++;
         $display("FAIL drain timeout: tx_busy %b, want 000", tx_busy);
      end
      repeat (4) tick();
   endtask

   initial begin
      logic [3:0] seq [NI];
      bit         seen;
      int         b0, e0, t0, n;
      logic       pre_busy;

      // Reset state
      #1 rst = 1; model_reset();
      #1;
      chk("reset wr_ready", 32'(wr_ready), 32'h7);
      chk("reset tx_busy", 32'(tx_busy), 32'h0);
      chk("reset pkt_cnt", 32'(pkt_cnt[0]), 32'h0);
      repeat (2) tick();
      rst = 0;
      repeat (2) tick();

      // 4-word packet: SOP at N+2, EOP 3 cycles later
      for (int k = 0; k < 4; k++) send_word(32'h11 + 32'(k), k == 3);
      tick();
      chk("t1 no sop at N+1", 32'(tx_sop[0]), 32'h0);
      tick();
      chk("t1 sop at N+2", 32'(tx_sop[0]), 32'h1);
      chk("t1 first data", tx_data[0], 32'h11);
      repeat (3) tick();
      chk("t1 eop at N+5", 32'(tx_eop[0]), 32'h1);
      chk("t1 last data", tx_data[0], 32'h14);
      wait_idle(200);

      // Two back-to-back 1-word packets on GAP 1/0/2
      send_word(32'h21, 1);
      send_word(32'h22, 1);
      for (int j = 0; j < 4; j++) begin
         tick();
         for (int i = 0; i < NI; i++) seq[i][j] = tx_sop[i] & tx_eop[i];
      end
      chk("t2 gap1 sop seq", 32'(seq[0]), 32'h5);
      chk("t2 gap0 sop seq", 32'(seq[1]), 32'h3);
      chk("t2 gap2 sop seq", 32'(seq[2]), 32'h9);
      wait_idle(200);

      // Stall holds off SOP; stall mid-packet is ignored
      tx_stall = 1;
      for (int k = 0; k < 4; k++) send_word(32'h31 + 32'(k), k == 3);
      seen = 0;
      for (int k = 0; k < 10; k++) begin tick(); seen |= tx_sop[0]; end
      chk("t3 no sop while stalled", 32'(seen), 32'h0);
      chk("t3 pkt_cnt held", 32'(pkt_cnt[0]), 32'h1);
      tx_stall = 0;
      tick();
      chk("t3 sop after release", 32'(tx_sop[0]), 32'h1);
      tx_stall = 1;
      repeat (3) tick();
      chk("t3 eop despite stall", 32'(tx_eop[0]), 32'h1);
      chk("t3 eop data", tx_data[0], 32'h34);
      tx_stall = 0;
      wait_idle(200);

      // 40-word packet truncated to 32
      b0 = busy_n; e0 = eop_n; t0 = trunc_n;
      for (int k = 0; k < 40; k++) send_word(32'h400 + 32'(k), k == 39);
      wait_idle(300);
      chk("t4 words sent", 32'(busy_n - b0), 32'd32);
      chk("t4 eop count", 32'(eop_n - e0), 32'd1);
      chk("t4 trunc pulses", 32'(trunc_n - t0), 32'd1);

      // Fill buffer while stalled, then drain
      tx_stall = 1;
      for (int k = 0; k < 64; k++) send_word(32'h500 + 32'(k), (k % 8) == 7);
      chk("t5 full wr_ready", 32'(wr_ready), 32'h0);
      tick();
      chk("t5 pkt_cnt full", 32'(pkt_cnt[0]), 32'd8);
      tx_stall = 0;
      n = 0;
      while (wr_ready !== 3'b111 && n < 10) begin tick(); n++; end
      chk("t5 wr_ready returns", 32'(wr_ready), 32'h7);
      wait_idle(400);

      // Randomized traffic with random stall
      rnd_mode = 1;
      for (int p = 0; p < 60; p++) begin
         int len;
         len = $urandom_range(1, 40);
         for (int w = 0; w < len; w++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) tick();
            send_word($urandom, w == len - 1);
         end
      end
      rnd_mode = 0;
      tx_stall = 0;
      wait_idle(3000);

      // Reset mid-packet while another packet is on the bus
      for (int k = 0; k < 6; k++) send_word(32'h60 + 32'(k), k == 5);
      send_word(32'h70, 0);
      send_word(32'h71, 0);
      pre_busy = tx_busy[0];
      chk("t6 busy before reset", 32'(pre_busy), 32'h1);
      wr_valid = 1; wr_data = 32'h72; wr_last = 0;
      #1 rst = 1;
      #1 model_reset();
      chk("t6 sop dropped", 32'(tx_sop), 32'h0);
      chk("t6 eop dropped", 32'(tx_eop), 32'h0);
      chk("t6 busy dropped", 32'(tx_busy), 32'h0);
      chk("t6 data dropped", tx_data[0], 32'h0);
      chk("t6 pkt_cnt cleared", 32'(pkt_cnt[0]), 32'h0);
      wr_valid = 0; wr_data = '0;
      repeat (2) tick();
      rst = 0;
      seen = 0;
      for (int k = 0; k < 10; k++) begin tick(); seen |= (tx_sop != '0); end
      chk("t6 no sop after reset", 32'(seen), 32'h0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
